// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator.
// Counts pixels/lines for the configured mode, decodes sync/visible/pulse
// flags from the counters and delays them all through 1+PIPE_DLY enabled
// stages so they stay mutually aligned at the outputs.
module vga_timing_gen #(
  parameter int CW       = 11,
  parameter int HD       = 640,
  parameter int HF       = 16,
  parameter int HS       = 96,
  parameter int HB       = 48,
  parameter int VD       = 480,
  parameter int VF       = 10,
  parameter int VS       = 2,
  parameter int VB       = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PIPE_DLY = 0       // 0..15
) (
  input  logic          pclk,
  input  logic          reset,     // asynchronous, active-low
  input  logic          ce,
  output logic          hsync,
  output logic          vsync,
  output logic          valid,
  output logic [CW-1:0] h_cnt,
  output logic [CW-1:0] v_cnt,
  output logic          line_start,
  output logic          frame_start
);

  localparam int HT  = HD + HF + HS + HB;
  localparam int VT  = VD + VF + VS + VB;
  localparam int NST = 1 + PIPE_DLY;

  localparam logic [CW-1:0] HT_M1  = CW'(HT - 1);
  localparam logic [CW-1:0] VT_M1  = CW'(VT - 1);
  localparam logic [CW-1:0] HD_C   = CW'(HD);
  localparam logic [CW-1:0] VD_C   = CW'(VD);
  localparam logic [CW-1:0] HSS_C  = CW'(HD + HF);
  localparam logic [CW-1:0] HSE_C  = CW'(HD + HF + HS);
  localparam logic [CW-1:0] VSS_C  = CW'(VD + VF);
  localparam logic [CW-1:0] VSE_C  = CW'(VD + VF + VS);

  // Sync is carried as an "active" flag so that the all-zero reset value of
  // a stage naturally maps to the inactive sync level at the output.
  typedef struct packed {
    logic          valid;
    logic          hact;
    logic          vact;
    logic          ls;
    logic          fs;
    logic [CW-1:0] h;
    logic [CW-1:0] v;
  } stage_t;

  logic [CW-1:0] px_q, px_d;
  logic [CW-1:0] ln_q, ln_d;
  stage_t        s0;
  stage_t        stg_q [NST];
  stage_t        stg_d [NST];

  // Next-state of the pixel/line counters; both hold when ce is low.
  always_comb begin
    px_d = px_q;
    ln_d = ln_q;
    if (ce) begin
      if (px_q == HT_M1) begin
        px_d = '0;
        ln_d = (ln_q == VT_M1) ? '0 : ln_q + CW'(1);
      end else begin
        px_d = px_q + CW'(1);
      end
    end
  end

  // Stage-0 decode of the current counter state.
  always_comb begin
    s0       = '0;
    s0.valid = (px_q < HD_C) && (ln_q < VD_C);
    s0.hact  = (px_q >= HSS_C) && (px_q < HSE_C);
    s0.vact  = (ln_q >= VSS_C) && (ln_q < VSE_C);
    s0.ls    = (px_q == '0);
    s0.fs    = (px_q == '0) && (ln_q == '0);
    s0.h     = (px_q < HD_C) ? px_q : '0;
    s0.v     = (ln_q < VD_C) ? ln_q : '0;
  end

  // Shift register next-state: advance one stage per enabled cycle.
  always_comb begin
    for (int i = 0; i < NST; i++) begin
      stg_d[i] = stg_q[i];
    end
    if (ce) begin
      stg_d[0] = s0;
      for (int i = 1; i < NST; i++) begin
        stg_d[i] = stg_q[i-1];
      end
    end
  end

  // Counter and pipeline registers with asynchronous clear.
  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      px_q <= '0;
      ln_q <= '0;
      for (int i = 0; i < NST; i++) begin
        stg_q[i] <= '0;
      end
    end else begin
      px_q <= px_d;
      ln_q <= ln_d;
      for (int i = 0; i < NST; i++) begin
        stg_q[i] <= stg_d[i];
      end
    end
  end

  // Outputs come straight from the last stage (polarity is a constant map).
  assign hsync       = stg_q[NST-1].hact ? HS_POL : ~HS_POL;
  assign vsync       = stg_q[NST-1].vact ? VS_POL : ~VS_POL;
  assign valid       = stg_q[NST-1].valid;
  assign h_cnt       = stg_q[NST-1].h;
  assign v_cnt       = stg_q[NST-1].v;
  assign line_start  = stg_q[NST-1].ls;
  assign frame_start = stg_q[NST-1].fs;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 mode plus a small 8x4 mode
// (PIPE_DLY 0 and 3, and inverted sync polarity), scoreboard-checked every
// cycle, with run-length and period measurements on the sync/pulse outputs.
module tb_vga_timing_gen;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        vld;
    logic        ls;
    logic        fs;
    logic [10:0] h;
    logic [10:0] v;
  } out_t;

  logic pclk = 1'b0;
  logic rst_n = 1'b1;
  logic ce = 1'b1;

  always #5 pclk = ~pclk;

  logic hsync_a, vsync_a, valid_a, ls_a, fs_a;
  logic hsync_b, vsync_b, valid_b, ls_b, fs_b;
  logic hsync_c, vsync_c, valid_c, ls_c, fs_c;
  logic hsync_d, vsync_d, valid_d, ls_d, fs_d;
  logic [10:0] h_a, v_a, h_b, v_b, h_c, v_c, h_d, v_d;

  vga_timing_gen u_a (
    .pclk(pclk), .reset(rst_n), .ce(ce), .hsync(hsync_a), .vsync(vsync_a),
    .valid(valid_a), .h_cnt(h_a), .v_cnt(v_a), .line_start(ls_a), .frame_start(fs_a));

  vga_timing_gen #(.HD(8), .HF(2), .HS(3), .HB(2), .VD(4), .VF(1), .VS(2), .VB(1)) u_b (
    .pclk(pclk), .reset(rst_n), .ce(ce), .hsync(hsync_b), .vsync(vsync_b),
    .valid(valid_b), .h_cnt(h_b), .v_cnt(v_b), .line_start(ls_b), .frame_start(fs_b));

  vga_timing_gen #(.HD(8), .HF(2), .HS(3), .HB(2), .VD(4), .VF(1), .VS(2), .VB(1),
                   .PIPE_DLY(3)) u_c (
    .pclk(pclk), .reset(rst_n), .ce(ce), .hsync(hsync_c), .vsync(vsync_c),
    .valid(valid_c), .h_cnt(h_c), .v_cnt(v_c), .line_start(ls_c), .frame_start(fs_c));

  vga_timing_gen #(.HD(8), .HF(2), .HS(3), .HB(2), .VD(4), .VF(1), .VS(2), .VB(1),
                   .HS_POL(1'b1), .VS_POL(1'b1)) u_d (
    .pclk(pclk), .reset(rst_n), .ce(ce), .hsync(hsync_d), .vsync(vsync_d),
    .valid(valid_d), .h_cnt(h_d), .v_cnt(v_d), .line_start(ls_d), .frame_start(fs_d));

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;
  int mult = 1;
  bit div4 = 1'b0;

  // Reference counters: default mode (a) and small mode (b, c, d).
  int pxa, lna, pxs, lns;
  out_t q_a[$], q_b[$], q_c[$], q_d[$];
  out_t cur_a, cur_b, cur_c, cur_d;

  // Measurement state.
  logic pv_hs_a = 1'b1, pv_vld_a = 1'b0, pv_ls_a = 1'b0;
  logic pv_hs_b = 1'b1, pv_vs_b = 1'b1, pv_fs_b = 1'b0;
  logic pv_hs_d = 1'b0, pv_vs_d = 1'b0;
  int rn_hs_a, rn_vld_a, rn_hs_b, rn_vs_b, rn_hs_d, rn_vs_d;
  int lt_ls_a, lt_fs_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic out_t exp_out(input int px, input int ln, input int hd, input int hf,
                                   input int hs, input int vd, input int vf, input int vs,
                                   input bit hp, input bit vp);
    out_t o;
    bit ha, va;
    ha    = (px >= hd + hf) && (px < hd + hf + hs);
    va    = (ln >= vd + vf) && (ln < vd + vf + vs);
    o.hs  = ha ? hp : !hp;
    o.vs  = va ? vp : !vp;
    o.vld = (px < hd) && (ln < vd);
    o.ls  = (px == 0);
    o.fs  = (px == 0) && (ln == 0);
    o.h   = (px < hd) ? 11'(px) : 11'd0;
    o.v   = (ln < vd) ? 11'(ln) : 11'd0;
    return o;
  endfunction

  function automatic out_t rst_out(input bit hp, input bit vp);
    out_t o;
    o    = '0;
    o.hs = !hp;
    o.vs = !vp;
    return o;
  endfunction

  task automatic model_reset();
    pxa = 0; lna = 0; pxs = 0; lns = 0;
    q_a.delete(); q_b.delete(); q_c.delete(); q_d.delete();
    repeat (3) q_c.push_back(rst_out(1'b0, 1'b0));
    cur_a = rst_out(1'b0, 1'b0);
    cur_b = rst_out(1'b0, 1'b0);
    cur_c = rst_out(1'b0, 1'b0);
    cur_d = rst_out(1'b1, 1'b1);
  endtask

  task automatic meas_invalidate();
    rn_hs_a = 0; rn_vld_a = 0; rn_hs_b = 0; rn_vs_b = 0; rn_hs_d = 0; rn_vs_d = 0;
    lt_ls_a = -1; lt_fs_b = -1;
  endtask

  // Length of each complete run at level act.
  task automatic rlen(input string tag, input logic cur, input logic act,
                      inout logic prev, inout int run, input int expw);
    if (cur == act && prev != act) run = 1;
    else if (cur == act && run > 0) run++;
    else if (cur != act && prev == act && run > 0) begin
      chk(tag, 32'(run), 32'(expw));
      run = 0;
    end
    prev = cur;
  endtask

  // Distance between successive rising edges.
  task automatic spc(input string tag, input logic cur, inout logic prev,
                     inout int last, input int expd);
    if (cur && !prev) begin
      if (last >= 0) chk(tag, 32'(cyc - last), 32'(expd));
      last = cyc;
    end
    prev = cur;
  endtask

  task automatic step();
    logic ce_e;
    ce_e = ce;
    @(posedge pclk);
    #1;
    cyc++;
    if (!rst_n) begin
      model_reset();
    end else if (ce_e) begin
      q_a.push_back(exp_out(pxa, lna, 640, 16, 96, 480, 10, 2, 1'b0, 1'b0));
      q_b.push_back(exp_out(pxs, lns, 8, 2, 3, 4, 1, 2, 1'b0, 1'b0));
      q_c.push_back(exp_out(pxs, lns, 8, 2, 3, 4, 1, 2, 1'b0, 1'b0));
      q_d.push_back(exp_out(pxs, lns, 8, 2, 3, 4, 1, 2, 1'b1, 1'b1));
      cur_a = q_a.pop_front();
      cur_b = q_b.pop_front();
      cur_c = q_c.pop_front();
      cur_d = q_d.pop_front();
      if (pxa == 799) begin pxa = 0; lna = (lna == 524) ? 0 : lna + 1; end
      else pxa++;
      if (pxs == 14) begin pxs = 0; lns = (lns == 7) ? 0 : lns + 1; end
      else pxs++;
    end
    chk("a_out", 32'({hsync_a, vsync_a, valid_a, ls_a, fs_a, h_a, v_a}), 32'(cur_a));
    chk("b_out", 32'({hsync_b, vsync_b, valid_b, ls_b, fs_b, h_b, v_b}), 32'(cur_b));
    chk("c_out", 32'({hsync_c, vsync_c, valid_c, ls_c, fs_c, h_c, v_c}), 32'(cur_c));
    chk("d_out", 32'({hsync_d, vsync_d, valid_d, ls_d, fs_d, h_d, v_d}), 32'(cur_d));
    chk("a_vmax", 32'(v_a <= 11'd479), 32'd1);
    rlen("a_hs_w",  hsync_a, 1'b0, pv_hs_a,  rn_hs_a,  mult * 96);
    rlen("a_vld_w", valid_a, 1'b1, pv_vld_a, rn_vld_a, mult * 640);
    spc ("a_ls_p",  ls_a,          pv_ls_a,  lt_ls_a,  mult * 800);
    rlen("b_hs_w",  hsync_b, 1'b0, pv_hs_b,  rn_hs_b,  mult * 3);
    rlen("b_vs_w",  vsync_b, 1'b0, pv_vs_b,  rn_vs_b,  mult * 30);
    spc ("b_fs_p",  fs_b,          pv_fs_b,  lt_fs_b,  mult * 120);
    rlen("d_hs_w",  hsync_d, 1'b1, pv_hs_d,  rn_hs_d,  mult * 3);
    rlen("d_vs_w",  vsync_d, 1'b1, pv_vs_d,  rn_vs_d,  mult * 30);
    ce = div4 ? ((cyc % 4) == 3) : 1'b1;
  endtask

  initial begin
    int k;
    model_reset();
    meas_invalidate();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_a", 32'({hsync_a, vsync_a, valid_a, ls_a, fs_a, h_a, v_a}), 32'(rst_out(1'b0, 1'b0)));
    chk("rst_c", 32'({hsync_c, vsync_c, valid_c, ls_c, fs_c, h_c, v_c}), 32'(rst_out(1'b0, 1'b0)));
    chk("rst_d", 32'({hsync_d, vsync_d, valid_d, ls_d, fs_d, h_d, v_d}), 32'(rst_out(1'b1, 1'b1)));
    repeat (2) step();
    rst_n = 1'b1;

    // First two enabled edges after release, default mode.
    step();
    chk("e1_fs", 32'(fs_a), 32'd1);
    chk("e1_ls", 32'(ls_a), 32'd1);
    chk("e1_vld", 32'(valid_a), 32'd1);
    chk("e1_h", 32'(h_a), 32'd0);
    chk("e1_v", 32'(v_a), 32'd0);
    chk("e1_c_fs", 32'(fs_c), 32'd0);
    step();
    chk("e2_fs", 32'(fs_a), 32'd0);
    chk("e2_h", 32'(h_a), 32'd1);
    step();
    step();
    chk("e4_c_fs", 32'(fs_c), 32'd1);

    // Free-running with ce held high.
    repeat (2500) step();

    // ce on every 4th cycle: all widths and periods scale by 4.
    div4 = 1'b1;
    mult = 4;
    meas_invalidate();
    repeat (7000) step();

    // Back to ce=1, then reset mid-line/mid-frame.
    div4 = 1'b0;
    mult = 1;
    meas_invalidate();
    k = 0;
    while (!(pxs == 5 && lns == 2) && k < 200) begin
      step();
      k++;
    end
    chk("mid_reach", 32'(pxs == 5 && lns == 2), 32'd1);
    #3 rst_n = 1'b0;
    meas_invalidate();
    #1;
    chk("mid_rst_a", 32'({hsync_a, vsync_a, valid_a, ls_a, fs_a, h_a, v_a}), 32'(rst_out(1'b0, 1'b0)));
    chk("mid_rst_b", 32'({hsync_b, vsync_b, valid_b, ls_b, fs_b, h_b, v_b}), 32'(rst_out(1'b0, 1'b0)));
    chk("mid_rst_c", 32'({hsync_c, vsync_c, valid_c, ls_c, fs_c, h_c, v_c}), 32'(rst_out(1'b0, 1'b0)));
    chk("mid_rst_d_hs", 32'(hsync_d), 32'd0);
    model_reset();
    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk("rel_fs_a", 32'(fs_a), 32'd1);
    chk("rel_fs_b", 32'(fs_b), 32'd1);
    chk("rel_h_b", 32'(h_b), 32'd0);
    repeat (300) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
